pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline register: owns the program counter.
//  Issues one-outstanding fetches to instruction memory over a req/gnt/rvalid handshake.
//  Presents each fetched {pc, pc_inst} for exactly one cycle; IF/ID samples it unconditionally.
//  Applies stall and branch redirect from decode/control. Bubbles are pc_inst = 0 (MIPS nop).
// PARAMETERS
//  RESET_PC   32'h0000_0000   first fetch address after reset
// PORTS
//  clk               in   1   single clock, rising edge
//  rst               in   1   asynchronous, active-low reset
//  stall             in   1   1 = do not present a new instruction this cycle
//  branch_flag       in   1   1-cycle redirect pulse from decode
//  branch_target     in   32  redirect address, valid with branch_flag
//  inst_req          out  1   fetch request to instruction memory
//  inst_addr         out  32  fetch address; stable while inst_req=1 and inst_gnt=0
//  inst_gnt          in   1   memory accepts request (inst_req & inst_gnt = handshake)
//  inst_rvalid       in   1   read data valid; earliest 1 cycle after gnt; one per gnt
//  inst_rdata        in   32  instruction word
//  pc                out  32  PC of presented instruction (to IF/ID)
//  pc_inst           out  32  presented instruction; 0 when no valid instruction
//  if_valid          out  1   1 for the single cycle an instruction is presented
// BEHAVIOUR
//  Reset (rst=0, async): state=S_RST; fetch_pc=RESET_PC; req_pc=0; pc=0; pc_inst=0; if_valid=0;
//   inst_req=0; inst_addr=0; held/kill/redirect flags=0. Reset mid-transfer abandons the fetch; late rvalid ignored.
//  FSM (registered):
//   S_RST : 1 bubble cycle after rst release -> S_REQ.
//   S_REQ : inst_req=1, inst_addr=fetch_pc. On gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32) -> S_WAIT.
//   S_WAIT: wait inst_rvalid. On rvalid, not killed: stall=0 -> load pc/pc_inst/if_valid, -> S_REQ;
//           stall=1 -> store in hold reg -> S_HOLD. Killed -> discard, clear kill, -> S_REQ.
//   S_HOLD: output bubble while stall=1; first cycle stall=0 -> present held word, -> S_REQ.
//  Output regs: load for exactly one cycle per presented instruction, else pc_inst=0, if_valid=0; pc holds last value.
//  Throughput: max 1 instruction / 2 cycles (gnt at t, rvalid t+1, output visible t+2, next req t+2).
//  Branch (branch_flag=1), all states, higher priority than stall:
//   S_REQ no gnt : inst_addr held; fetch_pc<=target; redirect_pend=1; granted data killed; next req = target.
//   S_REQ with gnt: fetch_pc<=target (not +4); this fetch killed.
//   S_WAIT       : fetch_pc<=target; kill=1; same-cycle rvalid is discarded directly.
//   S_HOLD       : held word dropped -> S_REQ at target.
//   Instruction already in output regs that cycle is still delivered (delay slot).
//   Branch on same cycle as stall: redirect taken, nothing presented.
//  Back-to-back branches: last target wins; at most one in-flight fetch killed.
// CONFIGURATION
//  IF_ALIGN_EXC_EN defined: target[1:0]!=0 -> no fetch issued; pc=target, pc_inst=0, extra out if_adel=1
//   for one cycle (outside stall); FSM parks in S_REQ with inst_req=0 until next branch_flag.
//  Undefined: if_adel port absent; target[1:0] forced to 2'b00.
// TESTING
//  Reset release, gnt=1, rdata 1-cycle -> inst_addr 0,4,8..; if_valid every 2nd cycle; pc_inst=rdata.
//  stall=1 for 3 cycles on rvalid @ pc 0x8 -> 3 bubbles (pc_inst=0), then pc=0x8 once, no duplicate.
//  branch_flag, target 0x100, in S_WAIT -> returned word dropped; next inst_addr=0x100; pc 0x100 next.
//  gnt low 4 cycles while branch to 0x40 -> inst_addr stays old until gnt; its data killed; then req 0x40.
//  rst low during S_WAIT, rvalid later -> all outputs 0; first req at RESET_PC after 1 bubble.
//  IF_ALIGN_EXC_EN, target 0x102 -> if_adel=1, pc=0x102, inst_req=0 until branch to 0x200.

Source files
------------

// File: rtl/pc_fetch_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_if: instruction-memory req/gnt/rvalid bus between fetch and imem.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pc_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_gnt,
    input  inst_rvalid,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_gnt,
    output inst_rvalid,
    output inst_rdata
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch.sv
// ----------------------------------------------------------------------------
// pc_fetch: PC owner and one-outstanding fetch FSM feeding IF/ID; optional
// misaligned-branch exception enabled by IF_ALIGN_EXC_EN.       Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        stall,
  input  wire logic        branch_flag,
  input  wire logic [31:0] branch_target,
  pc_fetch_if.master       imem,
  output logic [31:0]      pc,
  output logic [31:0]      pc_inst,
  output logic             if_valid
`ifdef IF_ALIGN_EXC_EN
  ,
  output logic             if_adel
`endif
);

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] addr_q;
  logic [31:0] hold_inst;
  logic        kill;
  logic        redirect_pend;
  logic        parked;
  logic [31:0] tgt;
  logic        bad;
  logic        hs;

`ifdef IF_ALIGN_EXC_EN
  assign tgt = branch_target;
  assign bad = |branch_target[1:0];
`else
  logic unused_tgt_bits;
  assign tgt             = {branch_target[31:2], 2'b00};
  assign bad             = 1'b0;
  assign unused_tgt_bits = ^branch_target[1:0];
`endif

  assign imem.inst_req  = (state == S_REQ) && !parked;
  assign imem.inst_addr = addr_q;
  assign hs             = imem.inst_req && imem.inst_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_RST;
      fetch_pc      <= RESET_PC;
      req_pc        <= 32'h0;
      addr_q        <= 32'h0;
      hold_inst     <= 32'h0;
      kill          <= 1'b0;
      redirect_pend <= 1'b0;
      parked        <= 1'b0;
      pc            <= 32'h0;
      pc_inst       <= 32'h0;
      if_valid      <= 1'b0;
`ifdef IF_ALIGN_EXC_EN
      if_adel       <= 1'b0;
`endif
    end else begin
      pc_inst  <= 32'h0;
      if_valid <= 1'b0;
`ifdef IF_ALIGN_EXC_EN
      if_adel  <= 1'b0;
`endif
      // A redirect always retargets fetch_pc; per-state handling below only
      // decides what happens to the request or data currently in flight.
      if (branch_flag) begin
        fetch_pc <= tgt;
        parked   <= bad;
`ifdef IF_ALIGN_EXC_EN
        if (bad) begin
          pc      <= branch_target;
          if_adel <= 1'b1;
        end
`endif
      end

      case (state)
        S_RST: begin
          state  <= S_REQ;
          addr_q <= branch_flag ? tgt : fetch_pc;
        end

        S_REQ: begin
          if (hs) begin
            state         <= S_WAIT;
            req_pc        <= addr_q;
            redirect_pend <= 1'b0;
            kill          <= branch_flag || redirect_pend;
            if (!branch_flag && !redirect_pend)
              fetch_pc <= fetch_pc + 32'd4;
          end else if (branch_flag) begin
            // An ungranted request must keep its address; retarget after it.
            if (imem.inst_req && !bad) begin
              redirect_pend <= 1'b1;
            end else begin
              addr_q        <= tgt;
              redirect_pend <= 1'b0;
            end
          end
        end

        S_WAIT: begin
          if (branch_flag) begin
            if (imem.inst_rvalid) begin
              state  <= S_REQ;
              addr_q <= tgt;
              kill   <= 1'b0;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem.inst_rvalid) begin
            if (kill) begin
              kill   <= 1'b0;
              state  <= S_REQ;
              addr_q <= fetch_pc;
            end else if (!stall) begin
              pc       <= req_pc;
              pc_inst  <= imem.inst_rdata;
              if_valid <= 1'b1;
              state    <= S_REQ;
              addr_q   <= fetch_pc;
            end else begin
              hold_inst <= imem.inst_rdata;
              state     <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (branch_flag) begin
            state  <= S_REQ;
            addr_q <= tgt;
          end else if (!stall) begin
            pc       <= req_pc;
            pc_inst  <= hold_inst;
            if_valid <= 1'b1;
            state    <= S_REQ;
            addr_q   <= fetch_pc;
          end
        end

        default: state <= S_RST;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch: directed vector table, reset corner case and randomized run
// against an instruction-stream model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_inst;
  logic        if_valid;
`ifdef IF_ALIGN_EXC_EN
  logic        if_adel;
`endif

  pc_fetch_if bus();

  pc_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_flag(branch_flag),
    .branch_target(branch_target),
    .imem(bus),
    .pc(pc),
    .pc_inst(pc_inst),
    .if_valid(if_valid)
`ifdef IF_ALIGN_EXC_EN
    ,
    .if_adel(if_adel)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        g;
    logic        b;
    logic [31:0] t;
    logic [127:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 0;
  logic        resp_pend = 1'b0;
  logic [31:0] resp_addr = 32'h0;
  int          resp_due = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'h24, a[23:0]};
  endfunction

  function automatic logic [127:0] pack(input logic rq, input logic [31:0] ad,
                                        input logic v, input logic [31:0] p,
                                        input logic [31:0] i);
    return {30'b0, rq, ad, v, p, i};
  endfunction

  function automatic logic [127:0] obs();
    return pack(bus.inst_req, bus.inst_addr, if_valid, pc, pc_inst);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Drive this cycle's inputs; the memory returns one response per grant.
  task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic g);
    stall         = s;
    branch_flag   = b;
    branch_target = t;
    bus.inst_gnt  = g;
    if (resp_pend && resp_due == cyc) begin
      bus.inst_rvalid = 1'b1;
      bus.inst_rdata  = mem_word(resp_addr);
      resp_pend       = 1'b0;
    end else begin
      bus.inst_rvalid = 1'b0;
      bus.inst_rdata  = $urandom;
    end
    if (rst && bus.inst_req && g) begin
      resp_pend = 1'b1;
      resp_addr = bus.inst_addr;
      resp_due  = cyc + 1 + lat;
    end
  endtask

  task automatic add(input logic s, input logic g, input logic b, input logic [31:0] t,
                     input logic rq, input logic [31:0] ad, input logic v, input logic [31:0] p);
    vec_t r;
    r.s = s; r.g = g; r.b = b; r.t = t;
    r.exp = pack(rq, ad, v, p, v ? mem_word(p) : 32'h0);
    vecs.push_back(r);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    resp_pend = 1'b0;
  endtask

  logic [31:0] exp_pc;
  logic        prev_s, prev_b, prev_v, prev_req, prev_g;
  logic [31:0] prev_addr;
  int          n_pres;

  initial begin
    bus.inst_gnt    = 1'b0;
    bus.inst_rvalid = 1'b0;
    bus.inst_rdata  = 32'h0;

    //      s  g  b  tgt           req addr        v  pc
    add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0);
    add(0, 1, 0, 32'h0,        1, 32'h0,     0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0);
    add(0, 1, 0, 32'h0,        1, 32'h4,     1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 32'h4,     0, 32'h0);
    add(0, 1, 0, 32'h0,        1, 32'h8,     1, 32'h4);
    add(1, 0, 0, 32'h0,        0, 32'h8,     0, 32'h4);
    add(1, 0, 0, 32'h0,        0, 32'h8,     0, 32'h4);
    add(1, 0, 0, 32'h0,        0, 32'h8,     0, 32'h4);
    add(0, 0, 0, 32'h0,        0, 32'h8,     0, 32'h4);
    add(0, 1, 0, 32'h0,        1, 32'hC,     1, 32'h8);
    add(0, 0, 1, 32'h100,      0, 32'hC,     0, 32'h8);
    add(0, 0, 1, 32'h40,       1, 32'h100,   0, 32'h8);
    add(0, 0, 0, 32'h0,        1, 32'h100,   0, 32'h8);
    add(0, 0, 0, 32'h0,        1, 32'h100,   0, 32'h8);
    add(0, 0, 0, 32'h0,        1, 32'h100,   0, 32'h8);
    add(0, 1, 0, 32'h0,        1, 32'h100,   0, 32'h8);
    add(0, 0, 0, 32'h0,        0, 32'h100,   0, 32'h8);
    add(0, 1, 0, 32'h0,        1, 32'h40,    0, 32'h8);
    add(0, 0, 0, 32'h0,        0, 32'h40,    0, 32'h8);
    add(0, 0, 0, 32'h0,        1, 32'h44,    1, 32'h40);

    tick();
    check("reset_state", obs(), pack(0, 0, 0, 0, 0));
    drive(0, 0, 32'h0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      if (i == 0) rst = 1'b1;
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
      drive(vecs[i].s, vecs[i].b, vecs[i].t, vecs[i].g);
    end

    // Reset while a fetch is outstanding; its late rvalid must be ignored.
    tick();
    check("pre_rst", obs(), pack(1, 32'h44, 0, 32'h40, 0));
    lat = 3;
    drive(0, 0, 32'h0, 1);
    tick();
    rst = 1'b0;
    #1;
    check("async_reset", obs(), pack(0, 0, 0, 0, 0));
    lat = 0;
    drive(0, 0, 32'h0, 0);
    tick();
    rst = 1'b1;
    check("rst_bubble", obs(), pack(0, 0, 0, 0, 0));
    drive(0, 0, 32'h0, 0);
    tick();
    check("first_req", obs(), pack(1, 0, 0, 0, 0));
    drive(0, 0, 32'h0, 0);
    tick();
    check("late_rvalid", obs(), pack(1, 0, 0, 0, 0));
    drive(0, 0, 32'h0, 0);
    tick();
    check("late_ignored", obs(), pack(1, 0, 0, 0, 0));
    drive(0, 0, 32'h0, 1);
    tick();
    check("restart_wait", obs(), pack(0, 0, 0, 0, 0));
    drive(0, 0, 32'h0, 0);
    tick();
    check("restart_pc0", obs(), pack(1, 32'h4, 1, 32'h0, mem_word(32'h0)));
    drive(0, 0, 32'h0, 0);

    // Randomized run: presented stream must be consecutive words restarting at each target.
    do_reset();
    rst = 1'b1;
    exp_pc = 32'h0;
    prev_s = 0; prev_b = 0; prev_v = 0; prev_req = 0; prev_g = 0; prev_addr = 0;
    n_pres = 0;
    for (int k = 0; k < 3000; k++) begin
      logic        s, b, g;
      logic [1:0]  lo;
      logic [31:0] t;
      tick();
      if (if_valid) begin
        check("rand_inst", {64'h0, pc, pc_inst}, {64'h0, exp_pc, mem_word(exp_pc)});
        check("rand_gap", {125'h0, prev_s, prev_b, prev_v}, 128'h0);
        exp_pc = exp_pc + 32'd4;
        n_pres++;
      end else begin
        check("rand_bubble", {96'h0, pc_inst}, 128'h0);
      end
      if (prev_req && !prev_g)
        check("addr_hold", {95'h0, bus.inst_req, bus.inst_addr}, {95'h0, 1'b1, prev_addr});
      prev_req  = bus.inst_req;
      prev_addr = bus.inst_addr;
      prev_v    = if_valid;
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 19) == 0);
      g   = ($urandom_range(0, 9) < 7);
`ifdef IF_ALIGN_EXC_EN
      lo  = 2'b00;
`else
      lo  = 2'($urandom_range(0, 3));
`endif
      t   = {20'h0, 10'($urandom_range(0, 1023)), lo};
      lat = $urandom_range(0, 2);
      drive(s, b, t, g);
      if (b) exp_pc = {t[31:2], 2'b00};
      prev_s = s;
      prev_b = b;
      prev_g = g;
    end
    check("rand_progress", {127'h0, n_pres > 100}, {127'h0, 1'b1});

`ifdef IF_ALIGN_EXC_EN
    lat = 0;
    do_reset();
    rst = 1'b1;
    tick();
    drive(0, 0, 32'h0, 0);
    tick();
    check("adel_pre", obs(), pack(1, 0, 0, 0, 0));
    drive(0, 1, 32'h102, 0);
    tick();
    check("adel_flag", {if_adel, obs()}, {1'b1, pack(0, 0, 0, 32'h102, 0)});
    drive(0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("adel_park", {126'h0, if_adel, bus.inst_req}, 128'h0);
      drive(0, i == 2, 32'h200, 1);
    end
    tick();
    check("adel_exit", {96'h0, bus.inst_addr} | {95'h0, bus.inst_req, 32'h0},
          {95'h0, 1'b1, 32'h200});
    drive(0, 0, 32'h0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
